// File: rtl/ssd_scan_decoder.sv
// Passive monitor for a multiplexed 4-digit seven-segment bus.
// It decodes scanned digits back into character codes and publishes complete frames with an error flag and a stability flag.
module ssd_scan_decoder #(
    parameter int TIMEOUT_CYC = 8,
    parameter int STABLE_CNT  = 3,
    parameter bit SEG_INV     = 1'b0
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic [3:0]  AN,
    input  logic [6:0]  SEG,
    output logic [15:0] DIGITS,
    output logic [3:0]  UNK,
    output logic        FRAME_VALID,
    output logic        FRAME_ERR,
    output logic        STABLE
);

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT_CYC - 1);
    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CNT);

    state_t      state_q;
    logic [3:0]  anSample_q;
    logic [6:0]  segSample_q;
    logic [15:0] shadowDigits_q, shadowDigits_d;
    logic [3:0]  shadowUnk_q, shadowUnk_d;
    logic [3:0]  seen_q, seen_d;
    logic [3:0]  timer_q;
    logic [3:0]  stableCnt_q, stableCnt_d;
    logic [15:0] digits_q;
    logic [3:0]  unk_q;
    logic        frameValid_q, frameErr_q, stable_q;

    logic [6:0]  segAdj;
    logic [3:0]  charCode;
    logic        charUnk;
    logic [3:0]  posMask;
    logic        isBad;
    logic        posValid;
    logic        frameSame;

    // Sampling stage: every later decision is based only on these registered copies of the bus.
    always_ff @(posedge DCLK) begin
        if (RST) begin
            anSample_q  <= 4'hF;
            segSample_q <= 7'h7F;
        end else begin
            anSample_q  <= AN;
            segSample_q <= SEG;
        end
    end

    always_comb begin
        segAdj   = segSample_q ^ {7{SEG_INV}};
        charUnk  = 1'b0;
        charCode = 4'hF;
        case (segAdj)
            7'b1000000: charCode = 4'h0;
            7'b1111001: charCode = 4'h1;
            7'b0100100: charCode = 4'h2;
            7'b0110000: charCode = 4'h3;
            7'b0011001: charCode = 4'h4;
            7'b0010010: charCode = 4'h5;
            7'b0000010: charCode = 4'h6;
            7'b1111000: charCode = 4'h7;
            7'b0000000: charCode = 4'h8;
            7'b0010000: charCode = 4'h9;
            7'b1011110: charCode = 4'hD;
            7'b1010100: charCode = 4'hB;
            7'b1010000: charCode = 4'hA;
            default:    charUnk  = 1'b1;
        endcase
    end

    always_comb begin
        posMask = 4'b0000;
        isBad   = 1'b0;
        case (anSample_q)
            4'b1110: posMask = 4'b0001;
            4'b1101: posMask = 4'b0010;
            4'b1011: posMask = 4'b0100;
            4'b0111: posMask = 4'b1000;
            4'b1111: posMask = 4'b0000;
            default: isBad   = 1'b1;
        endcase
        posValid = |posMask;
    end

    // Shadow frame including the digit seen this cycle, so completion can publish it immediately.
    always_comb begin
        shadowDigits_d = shadowDigits_q;
        shadowUnk_d    = shadowUnk_q;
        for (int i = 0; i < 4; i++) begin
            if (posMask[i]) begin
                shadowDigits_d[i*4 +: 4] = charCode;
                shadowUnk_d[i]           = charUnk;
            end
        end
        seen_d    = seen_q | posMask;
        frameSame = ({shadowDigits_d, shadowUnk_d} == {digits_q, unk_q});
        if (!frameSame)
            stableCnt_d = 4'd1;
        else if (stableCnt_q == STABLE_MAX)
            stableCnt_d = stableCnt_q;
        else
            stableCnt_d = stableCnt_q + 4'd1;
    end

    // Frame assembly; BAD beats completion, which beats timeout.
    always_ff @(posedge DCLK) begin
        if (RST) begin
            state_q        <= IDLE;
            shadowDigits_q <= 16'hFFFF;
            shadowUnk_q    <= 4'hF;
            seen_q         <= 4'h0;
            timer_q        <= 4'h0;
            stableCnt_q    <= 4'h0;
            digits_q       <= 16'hFFFF;
            unk_q          <= 4'hF;
            frameValid_q   <= 1'b0;
            frameErr_q     <= 1'b0;
            stable_q       <= 1'b0;
        end else begin
            frameValid_q <= 1'b0;
            frameErr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (isBad) begin
                        frameErr_q  <= 1'b1;
                        stableCnt_q <= 4'h0;
                        stable_q    <= 1'b0;
                    end else if (posValid) begin
                        shadowDigits_q <= shadowDigits_d;
                        shadowUnk_q    <= shadowUnk_d;
                        seen_q         <= posMask;
                        timer_q        <= 4'h0;
                        state_q        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (isBad || (seen_d != 4'hF && timer_q == TIMER_LAST)) begin
                        frameErr_q  <= 1'b1;
                        seen_q      <= 4'h0;
                        stableCnt_q <= 4'h0;
                        stable_q    <= 1'b0;
                        state_q     <= IDLE;
                    end else if (seen_d == 4'hF) begin
                        digits_q     <= shadowDigits_d;
                        unk_q        <= shadowUnk_d;
                        frameValid_q <= 1'b1;
                        seen_q       <= 4'h0;
                        stableCnt_q  <= stableCnt_d;
                        stable_q     <= (stableCnt_d == STABLE_MAX);
                        state_q      <= IDLE;
                    end else begin
                        shadowDigits_q <= shadowDigits_d;
                        shadowUnk_q    <= shadowUnk_d;
                        seen_q         <= seen_d;
                        timer_q        <= timer_q + 4'h1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DIGITS      = digits_q;
    assign UNK         = unk_q;
    assign FRAME_VALID = frameValid_q;
    assign FRAME_ERR   = frameErr_q;
    assign STABLE      = stable_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: it scans hand-built frames and checks the published outputs against hand-computed values.
module tb_ssd_scan_decoder;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b1011110, SN = 7'b1010100, SR = 7'b1010000;
    localparam logic [6:0] SX = 7'b1111111;

    logic        DCLK;
    logic        RST;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic [15:0] DIGITS;
    logic [3:0]  UNK;
    logic        FRAME_VALID, FRAME_ERR, STABLE;

    int compared   = 0;
    int mismatched = 0;

    ssd_scan_decoder #(.TIMEOUT_CYC(8), .STABLE_CNT(3), .SEG_INV(1'b0)) dut (
        .DCLK(DCLK), .RST(RST), .AN(AN), .SEG(SEG),
        .DIGITS(DIGITS), .UNK(UNK), .FRAME_VALID(FRAME_VALID),
        .FRAME_ERR(FRAME_ERR), .STABLE(STABLE)
    );

    initial DCLK = 1'b0;
    always #5 DCLK = ~DCLK;

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg);
        AN  = an;
        SEG = seg;
        @(posedge DCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Four digits in position order, then one blank tick so the last digit is processed.
    task automatic scanFrame(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2, input logic [6:0] d3);
        applyStimulus(4'b1110, d0);
        applyStimulus(4'b1101, d1);
        applyStimulus(4'b1011, d2);
        applyStimulus(4'b0111, d3);
        applyStimulus(4'b1111, SX);
    endtask

    initial begin
        RST = 1'b1;
        AN  = 4'hF;
        SEG = SX;
        applyStimulus(4'hF, SX);
        applyStimulus(4'hF, SX);
        checkOutput("rst_digits", 32'(DIGITS), 32'hFFFF);
        checkOutput("rst_unk", 32'(UNK), 32'hF);
        checkOutput("rst_flags", {29'd0, FRAME_VALID, FRAME_ERR, STABLE}, 32'h0);
        RST = 1'b0;

        applyStimulus(4'b1110, S9);
        applyStimulus(4'b1101, S6);
        applyStimulus(4'b1011, S7);
        applyStimulus(4'b0111, S0);
        checkOutput("t1_fv_early", 32'(FRAME_VALID), 32'h0);
        applyStimulus(4'hF, SX);
        checkOutput("t1_fv", 32'(FRAME_VALID), 32'h1);
        checkOutput("t1_digits", 32'(DIGITS), 32'h0769);
        checkOutput("t1_unk", 32'(UNK), 32'h0);
        applyStimulus(4'hF, SX);
        checkOutput("t1_fv_pulse", 32'(FRAME_VALID), 32'h0);

        applyStimulus(4'b1110, SR);
        applyStimulus(4'b1101, SN);
        applyStimulus(4'b1011, SD);
        for (int i = 0; i < 6; i++) applyStimulus(4'hF, SX);
        checkOutput("t2_fe_early", 32'(FRAME_ERR), 32'h0);
        applyStimulus(4'hF, SX);
        checkOutput("t2_fe_timeout", {30'd0, FRAME_ERR, FRAME_VALID}, 32'h2);
        checkOutput("t2_digits_hold", 32'(DIGITS), 32'h0769);
        applyStimulus(4'hF, SX);
        checkOutput("t2_fe_pulse", 32'(FRAME_ERR), 32'h0);
        scanFrame(SD, SN, SR, S0);
        checkOutput("t2_fv", 32'(FRAME_VALID), 32'h1);
        checkOutput("t2_digits", 32'(DIGITS), 32'h0ABD);

        scanFrame(S1, S2, S7, S9);
        checkOutput("t4_f1_stable", {30'd0, FRAME_VALID, STABLE}, 32'h2);
        scanFrame(S1, S2, S7, S9);
        checkOutput("t4_f2_stable", {30'd0, FRAME_VALID, STABLE}, 32'h2);
        scanFrame(S1, S2, S7, S9);
        checkOutput("t4_f3_stable", {30'd0, FRAME_VALID, STABLE}, 32'h3);
        checkOutput("t4_digits", 32'(DIGITS), 32'h9721);
        applyStimulus(4'hF, SX);
        checkOutput("t4_stable_hold", 32'(STABLE), 32'h1);
        scanFrame(S0, S2, S7, S9);
        checkOutput("t4_changed", {DIGITS, 14'd0, FRAME_VALID, STABLE}, {16'h9720, 16'h0002});
        scanFrame(S0, S2, S7, S9);
        scanFrame(S0, S2, S7, S9);
        checkOutput("t4_restable", 32'(STABLE), 32'h1);

        applyStimulus(4'b1110, S1);
        applyStimulus(4'b1101, S2);
        applyStimulus(4'b1100, S0);
        applyStimulus(4'hF, SX);
        checkOutput("t3_fe", {30'd0, FRAME_ERR, FRAME_VALID}, 32'h2);
        checkOutput("t3_digits_hold", 32'(DIGITS), 32'h9720);
        checkOutput("t3_stable_clr", 32'(STABLE), 32'h0);
        applyStimulus(4'b0000, S0);
        applyStimulus(4'hF, SX);
        checkOutput("t3_fe_idle", 32'(FRAME_ERR), 32'h1);

        scanFrame(S0, S1, SX, S2);
        checkOutput("t5_digits", 32'(DIGITS), 32'h2F10);
        checkOutput("t5_unk", 32'(UNK), 32'h4);
        applyStimulus(4'b1110, S0);
        applyStimulus(4'b1101, S1);
        applyStimulus(4'b1101, S7);
        applyStimulus(4'b1011, S9);
        applyStimulus(4'b0111, S2);
        applyStimulus(4'hF, SX);
        checkOutput("t5_repeat", {DIGITS, 12'd0, UNK}, {16'h2970, 16'h0000});

        applyStimulus(4'b1110, S9);
        applyStimulus(4'b1101, S9);
        RST = 1'b1;
        applyStimulus(4'hF, SX);
        checkOutput("t6_rst_digits", {DIGITS, 12'd0, UNK}, {16'hFFFF, 16'h000F});
        checkOutput("t6_rst_flags", {29'd0, FRAME_VALID, FRAME_ERR, STABLE}, 32'h0);
        RST = 1'b0;
        applyStimulus(4'b1011, S3);
        applyStimulus(4'b0111, S4);
        applyStimulus(4'hF, SX);
        checkOutput("t6_no_stale", 32'(FRAME_VALID), 32'h0);
        applyStimulus(4'b1110, S5);
        applyStimulus(4'b1101, S6);
        applyStimulus(4'hF, SX);
        checkOutput("t6_fv", {30'd0, FRAME_VALID, STABLE}, 32'h2);
        checkOutput("t6_digits", 32'(DIGITS), 32'h4365);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
